// File: rtl/instr_prefetch_queue_pkg.sv
// rtl/instr_prefetch_queue_pkg.sv - shared types and ring pointer helper for the prefetch queue
package pfq_pkg;

  typedef logic [15:0] halfword_t;

  localparam halfword_t NOP_HW = 16'h0000;

  // depth is always a power of two, so wrapping is a mask
  function automatic int ptr_add(input int ptr, input int n, input int depth);
    return (ptr + n) & (depth - 1);
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// rtl/instr_prefetch_queue_if.sv - ROM fetch, redirect and issue-slot signals of the prefetch queue
interface instr_prefetch_queue_if #(
  parameter int ADDR_W  = 14,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
);

  logic                         mem_req;
  logic [ADDR_W-1:0]            mem_addr;
  logic [16*FETCH_W-1:0]        mem_rdata;
  logic                         flush;
  logic [ADDR_W-1:0]            flush_addr;
  logic [ISSUE_W-1:0]           ir_valid;
  logic [16*ISSUE_W-1:0]        ir_data;
  logic [ADDR_W-1:0]            ir_pc;
  logic [$clog2(ISSUE_W+1)-1:0] issue_cnt;

  modport master (
    output mem_req, mem_addr, ir_valid, ir_data, ir_pc,
    input  mem_rdata, flush, flush_addr, issue_cnt
  );

  modport slave (
    input  mem_req, mem_addr, ir_valid, ir_data, ir_pc,
    output mem_rdata, flush, flush_addr, issue_cnt
  );

endinterface

// File: rtl/instr_prefetch_queue_ring.sv
// rtl/instr_prefetch_queue_ring.sv - halfword ring storage, one wide write port and ISSUE_W read ports
module pfq_ring
  import pfq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [PTR_W-1:0]       waddr,
  input  logic [16*FETCH_W-1:0]  wdata,
  input  logic [PTR_W-1:0]       raddr,
  output logic [16*ISSUE_W-1:0]  rdata
);

  halfword_t mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_HW;
    end else if (we) begin
      for (int k = 0; k < FETCH_W; k++)
        mem[PTR_W'(ptr_add(int'(waddr), k, DEPTH))] <= wdata[16*k +: 16];
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < ISSUE_W; i++)
      rdata[16*i +: 16] = mem[PTR_W'(ptr_add(int'(raddr), i, DEPTH))];
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - prefetch queue between program ROM and dual-issue Thumb decoder
module instr_prefetch_queue
  import pfq_pkg::*;
#(
  parameter int              ADDR_W     = 14,
  parameter int              FETCH_W    = 2,
  parameter int              ISSUE_W    = 2,
  parameter int              DEPTH      = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input logic                   clk,
  input logic                   rst,
  instr_prefetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_next, eff_cnt, wr_cnt, issue_ext;
  logic [CNT_W:0]    need;
  logic [ADDR_W-1:0] head_pc, fetch_pc, mem_addr_q;
  logic              mem_req_q, resp_pend, kill, live, issue_ok;

  // a response is dropped if it was killed by an earlier redirect or lands in a redirect cycle
  assign live = resp_pend & ~kill & ~bus.flush;

  always_comb begin
    issue_ext  = CNT_W'(bus.issue_cnt);
    eff_cnt    = (issue_ext < count) ? issue_ext : count;
    wr_cnt     = live ? CNT_W'(FETCH_W) : '0;
    count_next = count + wr_cnt - eff_cnt;
    // reserve room for the request already in flight plus the one being issued
    need       = (CNT_W+1)'(count_next) + (CNT_W+1)'(FETCH_W)
               + ((mem_req_q & ~bus.flush) ? (CNT_W+1)'(FETCH_W) : '0);
    issue_ok   = (need <= (CNT_W+1)'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_pc    <= RESET_ADDR;
      fetch_pc   <= RESET_ADDR;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_ADDR;
      resp_pend  <= 1'b0;
      kill       <= 1'b0;
    end else begin
      resp_pend <= mem_req_q;
      kill      <= bus.flush & mem_req_q;
      if (bus.flush) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        head_pc    <= bus.flush_addr;
        mem_req_q  <= 1'b1;
        mem_addr_q <= bus.flush_addr;
        fetch_pc   <= bus.flush_addr + ADDR_W'(FETCH_W);
      end else begin
        rd_ptr  <= PTR_W'(ptr_add(int'(rd_ptr), int'(eff_cnt), DEPTH));
        if (live) wr_ptr <= PTR_W'(ptr_add(int'(wr_ptr), FETCH_W, DEPTH));
        count   <= count_next;
        head_pc <= head_pc + ADDR_W'(eff_cnt);
        mem_req_q <= issue_ok;
        if (issue_ok) begin
          mem_addr_q <= fetch_pc;
          fetch_pc   <= fetch_pc + ADDR_W'(FETCH_W);
        end
      end
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.ir_pc    = head_pc;

  always_comb begin
    bus.ir_valid = '0;
    for (int i = 0; i < ISSUE_W; i++) bus.ir_valid[i] = (count > CNT_W'(i));
  end

  pfq_ring #(
    .DEPTH   (DEPTH),
    .FETCH_W (FETCH_W),
    .ISSUE_W (ISSUE_W)
  ) u_ring (
    .clk   (clk),
    .rst   (rst),
    .we    (live),
    .waddr (wr_ptr),
    .wdata (bus.mem_rdata),
    .raddr (rd_ptr),
    .rdata (bus.ir_data)
  );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - self-checking bench for instr_prefetch_queue
module tb_instr_prefetch_queue;
  import pfq_pkg::*;

  localparam int ADDR_W  = 14;
  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int DEPTH   = 8;
  localparam int IC_W    = $clog2(ISSUE_W + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_prefetch_queue_if #(.ADDR_W(ADDR_W), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) bus ();

  instr_prefetch_queue #(
    .ADDR_W(ADDR_W), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .RESET_ADDR(14'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic halfword_t rom_word(input logic [ADDR_W-1:0] a);
    return 16'hA000 + 16'(a);
  endfunction

  always @(posedge clk)
    for (int k = 0; k < FETCH_W; k++)
      bus.mem_rdata[16*k +: 16] <= rom_word(bus.mem_addr + ADDR_W'(k));

  typedef struct {
    logic [IC_W-1:0]        issue;
    logic                   exp_req;
    logic [ADDR_W-1:0]      exp_addr;
    logic [ISSUE_W-1:0]     exp_valid;
    logic [ADDR_W-1:0]      exp_pc;
    logic [16*ISSUE_W-1:0]  exp_data;
  } vec_t;

  vec_t tbl [7];
  int checks = 0;
  int errors = 0;
  int bubbles = 0;
  logic [ADDR_W-1:0] sb_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sb_reset(input logic [ADDR_W-1:0] start, input int n);
    sb_q.delete();
    for (int i = 0; i < n; i++) sb_q.push_back(start + ADDR_W'(i));
  endtask

  task automatic run_table();
    for (int c = 0; c < 7; c++) begin
      bus.issue_cnt = tbl[c].issue;
      step();
      check($sformatf("tbl%0d_req", c), 64'(bus.mem_req), 64'(tbl[c].exp_req));
      if (tbl[c].exp_req)
        check($sformatf("tbl%0d_addr", c), 64'(bus.mem_addr), 64'(tbl[c].exp_addr));
      check($sformatf("tbl%0d_valid", c), 64'(bus.ir_valid), 64'(tbl[c].exp_valid));
      check($sformatf("tbl%0d_pc", c), 64'(bus.ir_pc), 64'(tbl[c].exp_pc));
      check($sformatf("tbl%0d_data", c), 64'(bus.ir_data), 64'(tbl[c].exp_data));
    end
  endtask

  task automatic run_stream(input int ncyc, input int cnt, input bit want_full);
    for (int c = 0; c < ncyc; c++) begin
      int nv;
      int k;
      logic [ADDR_W-1:0] e;
      nv = $countones(bus.ir_valid);
      k  = (cnt < nv) ? cnt : nv;
      if (want_full && nv != ISSUE_W) bubbles++;
      for (int i = 0; i < k; i++) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got slot %0d expected queued entry", i);
        end else begin
          e = sb_q.pop_front();
          if (i == 0) check("stream_pc", 64'(bus.ir_pc), 64'(e));
          check($sformatf("stream_slot%0d", i), 64'(bus.ir_data[16*i +: 16]), 64'(rom_word(e)));
        end
      end
      bus.issue_cnt = IC_W'(k);
      step();
    end
    bus.issue_cnt = '0;
  endtask

  task automatic do_flush(input logic [ADDR_W-1:0] addr, input int cnt);
    bus.flush      = 1'b1;
    bus.flush_addr = addr;
    bus.issue_cnt  = IC_W'(cnt);
    step();
    bus.flush      = 1'b0;
    bus.issue_cnt  = '0;
    sb_reset(addr, 64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'd0, 1'b1, 14'h0, 2'b00, 14'h0, 32'h0};
    tbl[1] = '{2'd0, 1'b1, 14'h2, 2'b00, 14'h0, 32'h0};
    tbl[2] = '{2'd0, 1'b1, 14'h4, 2'b11, 14'h0, 32'hA001_A000};
    tbl[3] = '{2'd0, 1'b1, 14'h6, 2'b11, 14'h0, 32'hA001_A000};
    tbl[4] = '{2'd0, 1'b0, 14'h0, 2'b11, 14'h0, 32'hA001_A000};
    tbl[5] = '{2'd0, 1'b0, 14'h0, 2'b11, 14'h0, 32'hA001_A000};
    tbl[6] = '{2'd0, 1'b0, 14'h0, 2'b11, 14'h0, 32'hA001_A000};

    bus.flush      = 1'b0;
    bus.flush_addr = '0;
    bus.issue_cnt  = '0;

    @(negedge clk);
    @(negedge clk);
    check("rst_req",   64'(bus.mem_req),  64'd0);
    check("rst_addr",  64'(bus.mem_addr), 64'd0);
    check("rst_valid", 64'(bus.ir_valid), 64'd0);
    check("rst_pc",    64'(bus.ir_pc),    64'd0);
    check("rst_data",  64'(bus.ir_data),  64'd0);

    rst = 1'b0;
    sb_reset(14'h0, 256);
    run_table();

    run_stream(16, 2, 1'b1);
    check("no_bubble", 64'(bubbles), 64'd0);

    run_stream(24, 1, 1'b0);

    run_stream(10, 2, 1'b0);
    check("pre_flush_req", 64'(bus.mem_req), 64'd1);
    do_flush(14'h100, 0);
    check("fl_t1_valid", 64'(bus.ir_valid), 64'd0);
    check("fl_t1_req",   64'(bus.mem_req),  64'd1);
    check("fl_t1_addr",  64'(bus.mem_addr), 64'h100);
    step();
    check("fl_t2_valid", 64'(bus.ir_valid), 64'd0);
    step();
    check("fl_t3_valid", 64'(bus.ir_valid), 64'h3);
    check("fl_t3_pc",    64'(bus.ir_pc),    64'h100);
    check("fl_t3_data",  64'(bus.ir_data),  64'hA101_A100);
    run_stream(8, 2, 1'b0);

    do_flush(14'h200, 2);
    check("flc_valid", 64'(bus.ir_valid), 64'd0);
    check("flc_pc",    64'(bus.ir_pc),    64'h200);
    run_stream(10, 2, 1'b0);

    do_flush(14'h3FFF, 0);
    step();
    step();
    check("wrap_valid", 64'(bus.ir_valid), 64'h3);
    check("wrap_pc",    64'(bus.ir_pc),    64'h3FFF);
    check("wrap_data",  64'(bus.ir_data),  64'hA000_DFFF);
    run_stream(1, 1, 1'b0);
    check("wrap_pc0",   64'(bus.ir_pc),    64'h0);
    check("wrap_slot0", 64'(bus.ir_data[15:0]), 64'hA000);
    run_stream(8, 1, 1'b0);

    do_flush(14'h50, 0);
    step();
    step();
    check("mid_valid_pre", 64'(bus.ir_valid), 64'h3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req",   64'(bus.mem_req),  64'd0);
    check("arst_addr",  64'(bus.mem_addr), 64'd0);
    check("arst_valid", 64'(bus.ir_valid), 64'd0);
    check("arst_pc",    64'(bus.ir_pc),    64'd0);
    check("arst_data",  64'(bus.ir_data),  64'd0);
    step();
    rst = 1'b0;
    sb_reset(14'h0, 64);
    run_table();
    run_stream(10, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Parametrised instruction prefetch queue between the synchronous program ROM and the dual-issue Thumb decoder. It fetches FETCH_W consecutive halfwords per request and buffers them in a circular queue. It presents up to ISSUE_W in-order instruction slots per cycle, with their PC, and accepts a variable consume count. On a redirect (branch or exception) it flushes all buffered and in-flight data and restarts fetch at a new address.

## Interface
- ADDR_W, 14: halfword address width.
- FETCH_W, 2: halfwords returned per ROM request; 1, 2 or 4.
- ISSUE_W, 2: output slots; 1..4, ISSUE_W ≤ DEPTH.
- DEPTH, 8: queue entries in halfwords; power of two, ≥ 2*FETCH_W.
- RESET_ADDR, 0: fetch start address after reset.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  registered ROM read request.
- mem_addr  out  ADDR_W  registered halfword address of the request.
- mem_rdata  in  16*FETCH_W  ROM data, valid the cycle after mem_req; lane k = mem_addr+k.
- flush  in  1  redirect fetch.
- flush_addr  in  ADDR_W  redirect target.
- ir_valid  out  ISSUE_W  thermometer; bit i = slot i holds an instruction.
- ir_data  out  16*ISSUE_W  slot i = bits [16i+15:16i], program order.
- ir_pc  out  ADDR_W  halfword address of slot 0.
- issue_cnt  in  $clog2(ISSUE_W+1)  slots consumed this cycle.

## Operation
- State: ring storage, rd_ptr, wr_ptr, count (0..DEPTH), head_pc, fetch_pc, mem_req/mem_addr registers, kill bit.
- ir_valid[i] = (count > i). ir_data slot i = ring[rd_ptr+i] (mod DEPTH). All outputs derive from registers; there is no flush-to-output combinational path.
- Consume: the effective count is min(issue_cnt, count). Illegal values are clamped; the bench asserts they never occur. rd_ptr, head_pc and count advance by the effective count.
- Fill: the response is live when a request was made in the previous cycle and kill=0. A live response writes FETCH_W entries at wr_ptr (mod DEPTH, wrap allowed).
- Same-cycle write and consume: count_next = count + written - consumed.
- Issue rule, evaluated at each edge: set mem_req=1, mem_addr=fetch_pc and fetch_pc += FETCH_W when count_next + FETCH_W*(current mem_req & ~flush) + FETCH_W ≤ DEPTH. Otherwise mem_req=0. Overflow is impossible by construction.
- Flush has priority over consume, fill and issue in the same cycle:
  - count, rd_ptr and wr_ptr reset to 0.
  - Data arriving in the flush cycle is discarded.
  - kill is set if mem_req=1 in the flush cycle, so the next response is also discarded.
  - head_pc = flush_addr; mem_req=1, mem_addr=flush_addr; fetch_pc = flush_addr + FETCH_W.
- Addresses wrap modulo 2^ADDR_W.
- No 32-bit instruction pairing. BL halves are delivered as two slots.

## Timing
- Reset values:
  - mem_req 0, mem_addr RESET_ADDR, ir_valid 0, ir_pc RESET_ADDR, ir_data 0.
  - count 0, kill 0, fetch_pc RESET_ADDR.
- First edge after rst deasserts: mem_req=1 at RESET_ADDR.
- Fetch-to-valid latency: request in cycle C, data in C+1, slots valid in C+2.
- Flush in cycle T: mem_req at flush_addr in T+1, data in T+2, ir_valid in T+3 with ir_pc = flush_addr.
- Reset mid-operation clears everything immediately and asynchronously. Fetch restarts at RESET_ADDR.
- Steady state: FETCH_W ≥ ISSUE_W and DEPTH ≥ 3*FETCH_W sustain full-rate issue with no bubbles.

## Structure
- Package pfq_pkg holds:
  - halfword_t (logic [15:0]).
  - NOP_HW = 16'h0000.
  - Helper function ptr_add(ptr, n) for modulo-DEPTH arithmetic.
- Sub-module pfq_ring: DEPTH x 16 register file with one FETCH_W-wide write port at a wrapped index and ISSUE_W wrapped read ports. Pointers stay in the parent.

## Test plan
ROM model: mem_rdata lane k = 16'hA000 + (mem_addr+k). Defaults unless stated.
- Reset, issue_cnt=0 throughout:
  - mem_req cycle 1 at address 0, cycle 2 at address 2, cycle 3 at address 4.
  - Requests stop when count=8.
  - ir_data = {A001, A000}, ir_pc=0, ir_valid=2'b11, from cycle 3.
- issue_cnt=2 every cycle: ir_pc steps 0,2,4,… each cycle with no bubble after the first valid; data tracks ir_pc.
- issue_cnt=1 every cycle: odd ir_pc values appear; slot 1 = A000+ir_pc+1; wrap-around at rd_ptr 7→0 is seamless.
- Flush at 0x100 while mem_req=1 and a response is arriving:
  - Both stale responses are dropped.
  - ir_valid=0 for T+1 and T+2.
  - At T+3: ir_pc=0x100, ir_data = {A101, A100}.
- Flush in the same cycle as issue_cnt=2: the consume is ignored and the queue is empty next cycle.
- Flush at 0x3FFF (ADDR_W=14, FETCH_W=2): lanes are 0x3FFF and 0x0000, and ir_pc wraps to 0.
- Reset asserted mid-fill: all outputs return to reset values asynchronously, and fetch restarts at RESET_ADDR.
